// File: rtl/dcache_ctrl_if.sv
// Bus bundle for dcache_ctrl.
// Carries the CPU-side request/response signals (p1_*) and the line-wide memory-side
// signals (mem_*). Signal names keep the cache's point of view: *_i are driven into the
// cache, *_o are driven by the cache.
//   slave  : the cache controller itself.
//   master : the environment (CPU pipeline plus memory) that talks to the cache.
interface dcache_ctrl_if;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [127:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );

  modport master (
    output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 4 lines of 4 x 32-bit words. Hits are served combinationally in the request cycle;
// misses stall the pipeline, optionally write the dirty victim back, refill the line and
// then re-evaluate the still-held request as a hit.
// Ports:
//   clk_i  : clock, all state updates on the rising edge.
//   rst_i  : asynchronous active-low reset; clears valid/dirty and returns to idle.
//   bus    : dcache_ctrl_if.slave -- CPU request/response and memory line interface.
module dcache_ctrl (
  input logic          clk_i,
  input logic          rst_i,
  dcache_ctrl_if.slave bus
);

  localparam int unsigned NumLines = 4;
  localparam int unsigned TagW     = 26;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e                state_q, state_d;
  logic [NumLines-1:0]   valid_q, valid_d;
  logic [NumLines-1:0]   dirty_q, dirty_d;
  // Tag and data arrays carry no reset; valid_q gates every use of them.
  logic [TagW-1:0]       tag_q  [NumLines];
  logic [127:0]          line_q [NumLines];

  logic [1:0]            idx;
  logic [1:0]            off;
  logic [TagW-1:0]       req_tag;
  logic                  req;
  logic                  is_write;
  logic                  hit;
  logic                  line_we;
  logic                  tag_we;
  logic [127:0]          line_wdata;

  logic [31:0]           p1_data;
  logic                  p1_stall;
  logic [31:0]           mem_addr;
  logic [127:0]          mem_data;
  logic                  mem_enable;
  logic                  mem_write;

  assign idx     = bus.p1_addr_i[5:4];
  assign off     = bus.p1_addr_i[3:2];
  assign req_tag = bus.p1_addr_i[31:6];

  always_comb begin
    req      = bus.p1_MemRead_i | bus.p1_MemWrite_i;
    // A simultaneous read and write is a write.
    is_write = bus.p1_MemWrite_i;
    hit      = req && valid_q[idx] && (tag_q[idx] == req_tag);
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_wdata = line_q[idx];
    p1_data    = '0;
    p1_stall   = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    mem_enable = 1'b0;
    mem_write  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (hit) begin
            if (is_write) begin
              line_wdata[{off, 5'b0} +: 32] = bus.p1_data_i;
              line_we                       = 1'b1;
              dirty_d[idx]                  = 1'b1;
            end else begin
              p1_data = line_q[idx][{off, 5'b0} +: 32];
            end
          end else begin
            p1_stall = 1'b1;
            state_d  = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        p1_stall   = 1'b1;
        mem_enable = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[idx], idx, 4'b0};
        mem_data   = line_q[idx];
        if (bus.mem_ack_i) begin
          state_d = StAllocate;
        end
      end
      StAllocate: begin
        p1_stall   = 1'b1;
        mem_enable = 1'b1;
        mem_addr   = {req_tag, idx, 4'b0};
        if (bus.mem_ack_i) begin
          line_wdata   = bus.mem_data_i;
          line_we      = 1'b1;
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we) begin
      line_q[idx] <= line_wdata;
    end
    if (tag_we) begin
      tag_q[idx] <= req_tag;
    end
  end

  assign bus.p1_data_o    = p1_data;
  assign bus.p1_stall_o   = p1_stall;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_data_o   = mem_data;
  assign bus.mem_enable_o = mem_enable;
  assign bus.mem_write_o  = mem_write;

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 clk_i  input  1  clock; all state updates on posedge.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 p1_addr_i  input  32  CPU byte address (bits [1:0] ignored).
REQ-005 p1_data_i  input  32  CPU store data.
REQ-006 p1_MemRead_i  input  1  CPU load request.
REQ-007 p1_MemWrite_i  input  1  CPU store request.
REQ-008 p1_data_o  output  32  load data.
REQ-009 p1_stall_o  output  1  pipeline stall; high while the request is unserviced.
REQ-010 mem_addr_o  output  32  line-aligned memory address (bits [3:0] = 0).
REQ-011 mem_data_o  output  128  write-back line data.
REQ-012 mem_enable_o  output  1  memory request valid.
REQ-013 mem_write_o  output  1  1 = line write, 0 = line read.
REQ-014 mem_data_i  input  128  refill line data, valid with mem_ack_i.
REQ-015 mem_ack_i  input  1  one-cycle completion pulse from memory.

Function
REQ-016 Organisation SHALL be direct-mapped, write-back, write-allocate: 4 lines x 4 words; offset = addr[3:2], index = addr[5:4], tag = addr[31:6] (26 bits); per line one valid bit and one dirty bit.
REQ-017 Hit SHALL be defined as request & valid[index] & (tag match), evaluated combinationally.
REQ-018 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE.
REQ-019 IDLE, no request: p1_stall_o = 0, mem_enable_o = 0, p1_data_o = 0.
REQ-020 IDLE, read hit: p1_data_o = selected word in the same cycle, p1_stall_o = 0 (zero-latency hit).
REQ-021 IDLE, write hit: word replaced at the next posedge, dirty set, p1_stall_o = 0.
REQ-022 If MemRead and MemWrite are both high, the request SHALL be treated as a write.
REQ-023 IDLE, miss: p1_stall_o = 1 in the same cycle; next state = WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-024 WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 4'b0}, mem_data_o = victim line, all held until mem_ack_i; on ack the next state SHALL be ALLOCATE.
REQ-025 ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {request tag, index, 4'b0}, held until mem_ack_i; on ack mem_data_i SHALL be written to the line, with valid = 1, dirty = 0, tag updated, and next state = IDLE.
REQ-026 After a refill the request SHALL be re-evaluated in IDLE as a hit; a serviced miss therefore costs (writeback ack wait) + (allocate ack wait) + 1 cycles of stall.
REQ-027 p1_stall_o SHALL remain 1 throughout WRITEBACK and ALLOCATE.
REQ-028 The requester SHALL hold p1_* inputs stable while p1_stall_o = 1; the block SHALL NOT latch them.
REQ-029 mem_ack_i SHALL be ignored in IDLE.
REQ-030 mem_data_o SHALL be 0 outside WRITEBACK.
REQ-031 mem_addr_o SHALL be 0 when mem_enable_o = 0.

Reset
REQ-032 rst_i low SHALL immediately clear all valid and dirty bits, force the state to IDLE, and drive mem_enable_o = 0, mem_write_o = 0, and p1_stall_o = 0 (with no request).
REQ-033 A reset asserted during WRITEBACK or ALLOCATE SHALL abandon the transaction; the line is not updated.
REQ-034 Tag and data arrays need not be reset.

Verification
REQ-035 After reset, read 0x40 -> stall 1, ALLOCATE with mem_addr_o = 0x40; ack with line {W3..W0} = {4,3,2,1} -> next cycle p1_data_o = 1, stall 0.
REQ-036 Write 0x44 = 0xDEAD after REQ-035 -> no stall; then read 0x44 -> 0xDEAD; dirty[0] = 1.
REQ-037 Read 0x80 (same index 0, new tag) -> WRITEBACK at 0x40 with word1 = 0xDEAD, then ALLOCATE at 0x80; ack delays of 3 and 5 cycles -> stall held for exactly 9 cycles.
REQ-038 Read and write asserted together on a hit -> write performed, dirty set.
REQ-039 rst_i pulsed low mid-ALLOCATE -> mem_enable_o falls asynchronously; re-read of the same address misses again.
REQ-040 Miss on a clean valid line -> no WRITEBACK; goes directly to ALLOCATE.
